// File: rtl/key_cond_pkg.sv
// Shared types and constants for the key conditioner: channel FSM states,
// default cycle counts and the counter-width helper.
package key_cond_pkg;

   typedef enum logic [1:0] {
      REL   = 2'd0,
      CHK_P = 2'd1,
      HELD  = 2'd2,
      CHK_R = 2'd3
   } key_state_e;

   localparam int unsigned DB_CYCLES_DEF   = 1000000;
   localparam int unsigned LONG_CYCLES_DEF = 50000000;

   // Bits needed to hold 0..max_val, i.e. clog2(max_val+1), never less than 1.
   function automatic int clog2_width(input int unsigned max_val);
      int w;
      w = 1;
      while ((w < 32) && ((max_val >> w) != 0)) w++;
      return w;
   endfunction

endpackage

// File: rtl/key_cond_chan.sv
// One key channel: 2-FF synchroniser, debounce FSM, press/release pulses and,
// when KEY_CONDITIONER_LONG_PRESS_EN is defined, a single long-press pulse.
//
// state | meaning
// REL   | stable released
// CHK_P | low seen, qualifying a press
// HELD  | stable pressed, long counter running
// CHK_R | high seen, qualifying a release (long counter keeps running)
module key_cond_chan
   import key_cond_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic fpga_clk_50,
   input  logic hps_fpga_reset_n,
   input  logic key_n_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int CW = clog2_width(LONG_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LONG_CYCLES);

   key_state_e    state_q, state_d;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic          sync1_q, sync1_d, sync2_q, sync2_d;
   logic          level_q, level_d, press_q, press_d, release_q, release_d;

   always_comb begin
      sync1_d   = key_n_i;
      sync2_d   = sync1_q;
      state_d   = state_q;
      db_cnt_d  = db_cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         REL: begin
            if (!sync2_q) begin
               state_d  = CHK_P;
               db_cnt_d = CW'(1);
            end
         end
         CHK_P: begin
            if (sync2_q) begin
               state_d  = REL;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = HELD;
               level_d  = 1'b1;
               press_d  = 1'b1;
               db_cnt_d = '0;
            end else if (db_cnt_q != CNT_MAX) begin
               db_cnt_d = db_cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (sync2_q) begin
               state_d  = CHK_R;
               db_cnt_d = CW'(1);
            end
         end
         CHK_R: begin
            if (!sync2_q) begin
               state_d  = HELD;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d   = REL;
               level_d   = 1'b0;
               release_d = 1'b1;
               db_cnt_d  = '0;
            end else if (db_cnt_q != CNT_MAX) begin
               db_cnt_d = db_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d  = REL;
            db_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge fpga_clk_50) begin
      if (!hps_fpga_reset_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= REL;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

`ifdef KEY_CONDITIONER_LONG_PRESS_EN
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

   logic [CW-1:0] long_cnt_q, long_cnt_d;
   logic          long_q, long_d;

   // Counter saturates at LONG_CYCLES so the pulse fires only once per hold.
   always_comb begin
      long_cnt_d = long_cnt_q;
      long_d     = 1'b0;
      if ((state_q == CHK_P) && (state_d == HELD)) begin
         long_cnt_d = '0;
      end else if ((state_q == HELD) || (state_q == CHK_R)) begin
         if (state_d == REL) begin
            long_cnt_d = '0;
         end else if (long_cnt_q != CNT_MAX) begin
            long_cnt_d = long_cnt_q + CW'(1);
            long_d     = (long_cnt_q == LONG_LAST);
         end
      end
   end

   always_ff @(posedge fpga_clk_50) begin
      if (!hps_fpga_reset_n) begin
         long_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         long_cnt_q <= long_cnt_d;
         long_q     <= long_d;
      end
   end

   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: N_KEY independent debounced channels, active-low in,
// active-high level plus pulses out. Long press enabled by KEY_CONDITIONER_LONG_PRESS_EN.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int unsigned N_KEY       = 3,
   parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic             fpga_clk_50,
   input  logic             hps_fpga_reset_n,
   input  logic [N_KEY-1:0] key_n_i,
   output logic [N_KEY-1:0] key_level_o,
   output logic [N_KEY-1:0] key_press_o,
   output logic [N_KEY-1:0] key_release_o,
   output logic [N_KEY-1:0] key_long_o
);

   for (genvar g = 0; g < int'(N_KEY); g++) begin : g_chan
      key_cond_chan #(
         .DB_CYCLES   (DB_CYCLES),
         .LONG_CYCLES (LONG_CYCLES)
      ) u_chan (
         .fpga_clk_50      (fpga_clk_50),
         .hps_fpga_reset_n (hps_fpga_reset_n),
         .key_n_i          (key_n_i[g]),
         .level_o          (key_level_o[g]),
         .press_o          (key_press_o[g]),
         .release_o        (key_release_o[g]),
         .long_o           (key_long_o[g])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DB_CYCLES=4, LONG_CYCLES=10.
// Long-press expectations follow KEY_CONDITIONER_LONG_PRESS_EN.
module tb_key_conditioner;

   localparam int N = 3;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
   localparam int LONG_EN = 1;
`else
   localparam int LONG_EN = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] key_n;
   logic [N-1:0] level, press, rel, lng;

   int checks   = 0;
   int failures = 0;
   int cyc;
   int press_cnt[N], press_at[N], rel_cnt[N], rel_at[N], long_cnt[N], long_at[N];

   key_conditioner #(.N_KEY(3), .DB_CYCLES(4), .LONG_CYCLES(10)) dut (
      .fpga_clk_50      (clk),
      .hps_fpga_reset_n (rst_n),
      .key_n_i          (key_n),
      .key_level_o      (level),
      .key_press_o      (press),
      .key_release_o    (rel),
      .key_long_o       (lng)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      cyc = 0;
      for (int c = 0; c < N; c++) begin
         press_cnt[c] = 0; press_at[c] = 0;
         rel_cnt[c]   = 0; rel_at[c]   = 0;
         long_cnt[c]  = 0; long_at[c]  = 0;
      end
   endtask

   // Ticks n cycles, logging pulse counts and the tick index of the last pulse.
   task automatic run(input int n);
      repeat (n) begin
         tick();
         cyc++;
         for (int c = 0; c < N; c++) begin
            if (press[c]) begin press_cnt[c]++; press_at[c] = cyc; end
            if (rel[c])   begin rel_cnt[c]++;   rel_at[c]   = cyc; end
            if (lng[c])   begin long_cnt[c]++;  long_at[c]  = cyc; end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      key_n = 3'b000;

      // reset held with all keys down
      repeat (3) tick();
      chk("rst_level",   int'(level), 0);
      chk("rst_press",   int'(press), 0);
      chk("rst_release", int'(rel),   0);
      chk("rst_long",    int'(lng),   0);

      rst_n = 1'b1;
      clear();
      run(20);
      for (int c = 0; c < N; c++) begin
         chk($sformatf("post_rst_press_cnt%0d", c), press_cnt[c], 1);
         chk($sformatf("post_rst_press_at%0d", c), press_at[c], 6);
         chk($sformatf("post_rst_long_cnt%0d", c), long_cnt[c], LONG_EN);
      end
      chk("post_rst_level", int'(level), 7);
      key_n = 3'b111;
      clear();
      run(8);
      for (int c = 0; c < N; c++)
         chk($sformatf("post_rst_rel_at%0d", c), rel_at[c], 6);
      chk("post_rst_level_rel", int'(level), 0);

      // clean press on ch0, released 10 cycles later (just before long fires)
      key_n = 3'b110;
      clear();
      run(10);
      chk("clean_press_cnt", press_cnt[0], 1);
      chk("clean_press_at",  press_at[0], 6);
      chk("clean_level",     int'(level), 1);
      chk("clean_other",     press_cnt[1] + press_cnt[2], 0);
      key_n = 3'b111;
      clear();
      run(8);
      chk("clean_rel_cnt",  rel_cnt[0], 1);
      chk("clean_rel_at",   rel_at[0], 6);
      chk("clean_no_long",  long_cnt[0], 0);
      chk("clean_level_rel", int'(level), 0);

      // bounce on ch1: low 3, high 1, low 3, high
      clear();
      key_n = 3'b101; run(3);
      key_n = 3'b111; run(1);
      key_n = 3'b101; run(3);
      key_n = 3'b111; run(8);
      chk("bounce_press", press_cnt[1], 0);
      chk("bounce_rel",   rel_cnt[1], 0);
      chk("bounce_level", int'(level), 0);
      key_n = 3'b101;
      clear();
      run(10);
      chk("bounce_hold_press_cnt", press_cnt[1], 1);
      chk("bounce_hold_press_at",  press_at[1], 6);
      key_n = 3'b111;
      clear();
      run(8);
      chk("bounce_hold_rel_at", rel_at[1], 6);

      // long press ch2, held well past the long point
      key_n = 3'b011;
      clear();
      run(50);
      chk("long_press_at", press_at[2], 6);
      chk("long_cnt",      long_cnt[2], LONG_EN);
      chk("long_at",       long_at[2], LONG_EN ? 16 : 0);
      chk("long_only_ch2", int'(level), 4);
      key_n = 3'b111;
      clear();
      run(8);
      chk("long_rel_at", rel_at[2], 6);

      // long press with a 2-cycle release bounce mid-hold
      key_n = 3'b011;
      clear();
      run(8);
      key_n = 3'b111; run(2);
      key_n = 3'b011; run(20);
      chk("longb_press_cnt", press_cnt[2], 1);
      chk("longb_rel_cnt",   rel_cnt[2], 0);
      chk("longb_long_cnt",  long_cnt[2], LONG_EN);
      chk("longb_long_at",   long_at[2], LONG_EN ? 16 : 0);
      key_n = 3'b111;
      clear();
      run(8);
      chk("longb_rel_at", rel_at[2], 6);

      // simultaneous press on all channels
      key_n = 3'b000;
      run(5);
      chk("sim_before", int'(press), 0);
      tick();
      chk("sim_press",  int'(press), 7);
      chk("sim_level",  int'(level), 7);
      tick();
      chk("sim_after",  int'(press), 0);
      key_n = 3'b111;
      clear();
      run(8);
      chk("sim_rel_all", rel_cnt[0] + rel_cnt[1] + rel_cnt[2], 3);

      // reset during CHK_P on ch0, key kept held
      key_n = 3'b110;
      clear();
      run(3);
      rst_n = 1'b0;
      tick();
      chk("midrst_press0", int'(press), 0);
      chk("midrst_level0", int'(level), 0);
      tick();
      chk("midrst_press1", int'(press), 0);
      rst_n = 1'b1;
      clear();
      run(8);
      chk("midrst_press_cnt", press_cnt[0], 1);
      chk("midrst_press_at",  press_at[0], 6);
      chk("midrst_level",     int'(level), 1);
      key_n = 3'b111;
      clear();
      run(8);
      chk("midrst_rel_at", rel_at[0], 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
